// File: rtl/rf_write_arbiter_if.sv
// Writeback request channels, clear control and register-file write port
// bundled around rf_write_arbiter.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              init_start;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wd;
    logic              busy;

    // Writeback side: drives requests, observes grants and the write port.
    modport master (
        output init_start,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_we, rf_addr, rf_wd, busy
    );

    // Arbiter side.
    modport slave (
        input  init_start,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_we, rf_addr, rf_wd, busy
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: clears registers 1..NREG-1 after reset or
// on init_start, then shares the port round-robin between two writeback requesters.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    rf_write_arbiter_if.slave bus
);
    localparam logic [0:0]        INIT = 1'b0;
    localparam logic [0:0]        RUN  = 1'b1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              prio;
    logic              grant0;
    logic              grant1;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] rf_wd_q;

    // NOTE: defaults assigned first so every path drives both grants (no latch).
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == RUN && !bus.init_start) begin
            if (bus.req0_valid && (!bus.req1_valid || !prio)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= INIT;
            cnt       <= ADDR_W'(1);
            prio      <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_wd_q   <= '0;
        end else if (state == INIT) begin
            rf_we_q   <= 1'b1;
            rf_addr_q <= cnt;
            rf_wd_q   <= '0;
            if (cnt == LAST) begin
                state <= RUN;
                cnt   <= ADDR_W'(1);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (bus.init_start) begin
            state   <= INIT;
            cnt     <= ADDR_W'(1);
            rf_we_q <= 1'b0;
        end else if (grant0) begin
            // Register 0 is hardwired; the write is consumed but never issued.
            rf_we_q   <= (bus.req0_addr != '0);
            rf_addr_q <= bus.req0_addr;
            rf_wd_q   <= bus.req0_data;
            prio      <= 1'b1;
        end else if (grant1) begin
            rf_we_q   <= (bus.req1_addr != '0);
            rf_addr_q <= bus.req1_addr;
            rf_wd_q   <= bus.req1_data;
            prio      <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_addr    = rf_addr_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.busy       = (state == INIT);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a reference model pushes the expected
// write-port value every cycle and a register-file model records the writes.
module tb_rf_write_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    logic preload;

    rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Register file behind the write port; raw storage, so a stray write to
    // register 0 stays visible.
    logic [DATA_W-1:0] mem [NREG];
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < NREG; i++) mem[i] <= (i == 0) ? '0 : (32'hBAD0_0000 | i);
        end else if (bus.rf_we) begin
            mem[bus.rf_addr] <= bus.rf_wd;
        end
    end

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    // Reference model state.
    logic              m_init;
    logic [ADDR_W-1:0] m_cnt;
    logic              m_prio;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wd;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1;
        m_cnt  = ADDR_W'(1);
        m_prio = 1'b0;
        m_addr = '0;
        m_wd   = '0;
        sb.delete();
    endtask

    // One clock: check grants mid-cycle, push the expected write-port value,
    // then pop and compare it just after the rising edge.
    task automatic cycle();
        logic e_r0, e_r1;
        exp_t e, got;
        @(negedge CLK);
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!m_init && !bus.init_start) begin
            if (bus.req0_valid && (!bus.req1_valid || m_prio == 1'b0)) e_r0 = 1'b1;
            else if (bus.req1_valid) e_r1 = 1'b1;
        end
        check("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
        check("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
        check("busy", 32'(bus.busy), 32'(m_init));
        e.we = 1'b0;
        if (m_init) begin
            e.we   = 1'b1;
            m_addr = m_cnt;
            m_wd   = '0;
            if (m_cnt == ADDR_W'(NREG - 1)) begin
                m_init = 1'b0;
                m_cnt  = ADDR_W'(1);
            end else begin
                m_cnt = m_cnt + 1'b1;
            end
        end else if (bus.init_start) begin
            m_init = 1'b1;
            m_cnt  = ADDR_W'(1);
        end else if (e_r0) begin
            e.we   = (bus.req0_addr != 0);
            m_addr = bus.req0_addr;
            m_wd   = bus.req0_data;
            m_prio = 1'b1;
        end else if (e_r1) begin
            e.we   = (bus.req1_addr != 0);
            m_addr = bus.req1_addr;
            m_wd   = bus.req1_data;
            m_prio = 1'b0;
        end
        e.addr = m_addr;
        e.wd   = m_wd;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        check("rf_we", 32'(bus.rf_we), 32'(got.we));
        check("rf_addr", 32'(bus.rf_addr), 32'(got.addr));
        check("rf_wd", bus.rf_wd, got.wd);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
        check({tag, "_rf_addr"}, 32'(bus.rf_addr), 32'd0);
        check({tag, "_rf_wd"}, bus.rf_wd, 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N          = 1'b0;
        preload        = 1'b1;
        bus.init_start = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        model_reset();

        // Reset state, then the 31-write clear and one idle RUN cycle.
        @(posedge CLK);
        @(posedge CLK);
        #1;
        preload = 1'b0;
        check_reset_outputs("reset");
        check("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
        RST_N = 1'b1;
        cycles(NREG - 1);
        cycle();
        for (int i = 0; i < NREG; i++) check($sformatf("clear_reg%0d", i), mem[i], 32'd0);

        // Single requester.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd5;
        bus.req0_data  = 32'hDEAD_BEEF;
        cycle();
        bus.req0_valid = 1'b0;
        cycle();
        check("single_reg5", mem[5], 32'hDEAD_BEEF);

        // Address zero: accepted, discarded, still flips priority.
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 5'd0;
        bus.req1_data  = 32'hFFFF_FFFF;
        cycle();
        bus.req1_valid = 1'b0;
        cycle();
        check("addr0_reg0", mem[0], 32'd0);

        // Contention: grants alternate 0,1,0,1 starting from requester 0.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd3;
        bus.req0_data  = 32'h11;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 5'd4;
        bus.req1_data  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("contend_grant%0d", i), 32'(bus.req1_ready), 32'(i % 2));
            #1;
            cycle_no_wait();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cycle();
        check("contend_reg3", mem[3], 32'h11);
        check("contend_reg4", mem[4], 32'h22);

        // Write reg 9, then re-clear with a request held across the clear.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd9;
        bus.req0_data  = 32'hA5;
        cycle();
        bus.req0_valid = 1'b0;
        cycle();
        check("init_reg9_before", mem[9], 32'hA5);
        bus.init_start = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd7;
        bus.req0_data  = 32'h55;
        cycle();
        bus.init_start = 1'b0;
        cycles(10);
        bus.init_start = 1'b1;
        cycle();
        bus.init_start = 1'b0;
        cycles(NREG - 1 - 11);
        cycle();
        bus.req0_valid = 1'b0;
        cycle();
        cycle();
        check("init_reg9_after", mem[9], 32'd0);
        check("held_reg7", mem[7], 32'h55);

        // Reset in the middle of a clear: outputs drop at once, clear restarts.
        bus.init_start = 1'b1;
        cycle();
        bus.init_start = 1'b0;
        cycles(12);
        check("midclear_addr", 32'(bus.rf_addr), 32'd12);
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cycles(NREG - 1);
        cycle();
        check("restart_reg12", mem[12], 32'd0);
        check("restart_reg31", mem[31], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Remainder of cycle() once the negedge has already been reached.
    task automatic cycle_no_wait();
        logic e_r0, e_r1;
        exp_t e, got;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!m_init && !bus.init_start) begin
            if (bus.req0_valid && (!bus.req1_valid || m_prio == 1'b0)) e_r0 = 1'b1;
            else if (bus.req1_valid) e_r1 = 1'b1;
        end
        check("c_req0_ready", 32'(bus.req0_ready), 32'(e_r0));
        check("c_req1_ready", 32'(bus.req1_ready), 32'(e_r1));
        e.we = 1'b0;
        if (e_r0) begin
            e.we   = (bus.req0_addr != 0);
            m_addr = bus.req0_addr;
            m_wd   = bus.req0_data;
            m_prio = 1'b1;
        end else if (e_r1) begin
            e.we   = (bus.req1_addr != 0);
            m_addr = bus.req1_addr;
            m_wd   = bus.req1_data;
            m_prio = 1'b0;
        end
        e.addr = m_addr;
        e.wd   = m_wd;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        check("c_rf_we", 32'(bus.rf_we), 32'(got.we));
        check("c_rf_addr", 32'(bus.rf_addr), 32'(got.addr));
        check("c_rf_wd", bus.rf_wd, got.wd);
    endtask
endmodule
